// File: rtl/challenge_sequencer.sv
// Challenge-mode game controller: draws SEQ_LEN digits from the LFSR,
// presents them to the Morse encoder, then checks the user's answer.
module challenge_sequencer #(
  parameter int SEQ_LEN   = 4,
  parameter int IDX_W     = 3,
  parameter int NO_REPEAT = 1,
  parameter int MAX_RETRY = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       replay,
  input  logic       abort,
  output logic       rng_en,
  input  logic [3:0] rng_rand,
  output logic [3:0] digit_out,
  output logic       digit_valid,
  input  logic       digit_ready,
  input  logic [3:0] guess_digit,
  input  logic       guess_valid,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       have_seq
);

  localparam int RW = (MAX_RETRY < 1) ? 1
                    : $clog2(MAX_RETRY + 1);
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(SEQ_LEN - 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    GEN_REQ,
    GEN_WAIT,
    GEN_CAP,
    PRESENT,
    CHECK,
    RESULT
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             pass_q, pass_d;
  logic             have_q, have_d;
  logic [3:0]       mem_q [DEPTH];
  logic             wr_en;
  logic [3:0]       wr_data;

  logic [3:0] cur;
  logic [3:0] prev;
  logic       oor;
  logic       rep;
  logic       reject;
  logic       in_gen;

  assign cur    = mem_q[idx_q];
  assign prev   = mem_q[idx_q - 1'b1];
  assign oor    = rng_rand > 4'd9;
  assign rep    = (NO_REPEAT != 0) &&
                  (idx_q != '0) &&
                  (rng_rand == prev);
  assign reject = oor || rep;
  assign in_gen = (state_q == GEN_REQ) ||
                  (state_q == GEN_WAIT) ||
                  (state_q == GEN_CAP);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    pass_d  = pass_q;
    have_d  = have_q;
    wr_en   = 1'b0;
    wr_data = rng_rand;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = GEN_REQ;
          idx_d   = '0;
          retry_d = '0;
          pass_d  = 1'b0;
          have_d  = 1'b0;
        end else if (replay && have_q) begin
          state_d = PRESENT;
          idx_d   = '0;
        end
      end
      GEN_REQ:  state_d = GEN_WAIT;
      GEN_WAIT: state_d = GEN_CAP;
      GEN_CAP: begin
        if (reject && (retry_q < RMAX)) begin
          retry_d = retry_q + 1'b1;
          state_d = GEN_REQ;
        end else begin
          wr_en   = 1'b1;
          // a stale out-of-range value is folded into 0..5
          wr_data = oor ? rng_rand - 4'd10
                        : rng_rand;
          retry_d = '0;
          if (idx_q == LAST) begin
            have_d  = 1'b1;
            idx_d   = '0;
            state_d = PRESENT;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = GEN_REQ;
          end
        end
      end
      PRESENT: begin
        if (digit_ready) begin
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = CHECK;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      CHECK: begin
        if (guess_valid) begin
          if (guess_digit != cur) begin
            pass_d  = 1'b0;
            state_d = RESULT;
          end else if (idx_q == LAST) begin
            pass_d  = 1'b1;
            state_d = RESULT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      RESULT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      idx_d   = '0;
      retry_d = '0;
      pass_d  = 1'b0;
      wr_en   = 1'b0;
      if (in_gen) have_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      retry_q <= '0;
      pass_q  <= 1'b0;
      have_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      pass_q  <= pass_d;
      have_q  <= have_d;
      if (wr_en) mem_q[idx_q] <= wr_data;
    end
  end

  assign rng_en      = state_q == GEN_REQ;
  assign digit_valid = state_q == PRESENT;
  assign digit_out   = digit_valid ? cur : '0;
  assign busy        = state_q != IDLE;
  assign done        = state_q == RESULT;
  assign pass        = pass_q;
  assign have_seq    = have_q;

endmodule

// File: tb/tb_challenge_sequencer.sv
// Randomised bench for challenge_sequencer with a
// rule-level model of digit drawing and checking.
module tb_challenge_sequencer;

  localparam int SEQ_LEN   = 4;
  localparam int MAX_RETRY = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       replay = 1'b0;
  logic       abort = 1'b0;
  logic       digit_ready = 1'b0;
  logic       guess_valid = 1'b0;
  logic [3:0] guess_digit = '0;
  logic [3:0] rng_rand = '0;
  logic       rng_en;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic       busy;
  logic       done;
  logic       pass;
  logic       have_seq;

  challenge_sequencer #(
    .SEQ_LEN(SEQ_LEN),
    .IDX_W(3),
    .NO_REPEAT(1),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .replay(replay),
    .abort(abort),
    .rng_en(rng_en),
    .rng_rand(rng_rand),
    .digit_out(digit_out),
    .digit_valid(digit_valid),
    .digit_ready(digit_ready),
    .guess_digit(guess_digit),
    .guess_valid(guess_valid),
    .busy(busy),
    .done(done),
    .pass(pass),
    .have_seq(have_seq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int stub_q[$];
  int stim[$];
  int gq[$];
  int exp_seq[$];
  int n_used;
  int rng_cnt = 0;
  int done_cnt = 0;

  // generator stub: registers the next draw when enabled
  always @(posedge clk) begin
    if (rng_en) begin
      rng_cnt++;
      if (stub_q.size() > 0)
        rng_rand <= 4'(stub_q.pop_front());
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  task automatic model();
    exp_seq = {};
    n_used = 0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      int rej;
      rej = 0;
      while (n_used < stim.size()) begin
        int v;
        bit bad;
        v = stim[n_used];
        n_used++;
        bad = (v > 9) ||
              (i > 0 && v == exp_seq[i-1]);
        if (!bad) begin
          exp_seq.push_back(v);
          break;
        end
        if (rej == MAX_RETRY) begin
          exp_seq.push_back(v > 9 ? v - 10 : v);
          break;
        end
        rej++;
      end
    end
  endtask

  task automatic gen();
    int n;
    model();
    stub_q = {};
    for (int i = 0; i < n_used; i++)
      stub_q.push_back(stim[i]);
    rng_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      start = 1'b0;
      if (digit_valid) break;
      @(posedge clk);
      n++;
    end
    chk("gen_cycles", n, 3 * n_used);
    chk("rng_pulses", rng_cnt, n_used);
    chk("have_seq_gen", have_seq, 1);
    chk("busy_present", busy, 1);
  endtask

  task automatic present(input int cnt,
                         input int maxw);
    for (int i = 0; i < cnt; i++) begin
      int w;
      w = $urandom_range(0, maxw);
      repeat (w) begin
        chk("hold_valid", digit_valid, 1);
        chk("hold_digit", digit_out, exp_seq[i]);
        @(negedge clk);
      end
      chk("digit_valid", digit_valid, 1);
      chk("digit", digit_out, exp_seq[i]);
      digit_ready = 1'b1;
      @(negedge clk);
      digit_ready = 1'b0;
    end
    if (cnt == SEQ_LEN) begin
      chk("check_novalid", digit_valid, 0);
      chk("check_busy", busy, 1);
    end
  endtask

  task automatic guess();
    bit exp_pass;
    exp_pass = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < gq.size(); i++) begin
      bit fin;
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("done_idle_gap", done, 0);
      end
      guess_digit = 4'(gq[i]);
      guess_valid = 1'b1;
      @(negedge clk);
      guess_valid = 1'b0;
      if (gq[i] != exp_seq[i]) exp_pass = 1'b0;
      fin = (gq[i] != exp_seq[i]) ||
            (i == SEQ_LEN - 1);
      chk("done_pulse", done, int'(fin));
      if (fin) break;
    end
    @(negedge clk);
    chk("done_once", done, 0);
    chk("busy_after", busy, 0);
    chk("pass", pass, int'(exp_pass));
    chk("have_seq_after", have_seq, 1);
    chk("done_count", done_cnt, 1);
    guess_digit = 4'(exp_seq[0] ^ 1);
    guess_valid = 1'b1;
    @(negedge clk);
    guess_valid = 1'b0;
    @(negedge clk);
    chk("stray_pass", pass, int'(exp_pass));
    chk("stray_done", done_cnt, 1);
    chk("stray_busy", busy, 0);
  endtask

  task automatic good_guesses();
    gq = {};
    foreach (exp_seq[i]) gq.push_back(exp_seq[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rng_en", rng_en, 0);
    chk("rst_digit_out", digit_out, 0);
    chk("rst_valid", digit_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_have", have_seq, 0);
    rst = 1'b1;
    @(negedge clk);

    stim = {3, 7, 1, 9};
    gen();
    @(negedge clk);
    chk("d0", digit_out, exp_seq[0]);
    digit_ready = 1'b1;
    @(negedge clk);
    digit_ready = 1'b0;
    repeat (5) begin
      chk("stall_digit", digit_out, 7);
      @(negedge clk);
    end
    digit_ready = 1'b1;
    @(negedge clk);
    digit_ready = 1'b0;
    repeat (2) begin
      digit_ready = 1'b1;
      @(negedge clk);
      digit_ready = 1'b0;
    end
    chk("t1_in_check", digit_valid, 0);
    good_guesses();
    guess();

    stim = {3, 7, 1, 9};
    gen();
    present(SEQ_LEN, 1);
    gq = {3, 5, 1, 9};
    guess();

    stim = {4, 4, 4, 6};
    repeat (8) stim.push_back(6);
    repeat (8) stim.push_back(12);
    gen();
    present(SEQ_LEN, 2);
    good_guesses();
    guess();

    stim = {4};
    repeat (8) stim.push_back(4);
    repeat (8) stim.push_back(12);
    stim.push_back(5);
    gen();
    present(SEQ_LEN, 0);
    good_guesses();
    guess();

    stim = {2, 8, 0, 5};
    gen();
    done_cnt = 0;
    present(2, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy_ign", busy, 1);
    chk("start_valid_ign", digit_valid, 1);
    chk("start_digit_ign", digit_out, exp_seq[2]);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", digit_valid, 0);
    chk("abort_pass", pass, 0);
    chk("abort_have", have_seq, 1);
    @(negedge clk);
    chk("abort_nodone", done_cnt, 0);
    rng_cnt = 0;
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    chk("replay_valid", digit_valid, 1);
    present(SEQ_LEN, 2);
    chk("replay_no_rng", rng_cnt, 0);
    good_guesses();
    guess();

    stim = {1, 2, 3, 4};
    model();
    stub_q = {1, 2, 3, 4};
    @(negedge clk);
    start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("gabort_busy", busy, 0);
    chk("gabort_have", have_seq, 0);
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    chk("replay_no_seq", busy, 0);

    stim = {6, 6, 1, 1, 2, 3};
    gen();
    present(SEQ_LEN, 0);
    good_guesses();
    guess();
    stub_q = {5, 9, 0, 0};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pre_rst_rng", rng_en, 1);
    rst = 1'b0;
    #1;
    chk("arst_rng_en", rng_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", digit_valid, 0);
    chk("arst_digit", digit_out, 0);
    chk("arst_have", have_seq, 0);
    chk("arst_pass", pass, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    stub_q = {};
    rst = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 25; t++) begin
      int last;
      stim = {};
      last = 0;
      for (int k = 0; k < 40; k++) begin
        int r, v;
        r = $urandom_range(0, 9);
        if (r < 3) v = last;
        else if (r < 5) v = $urandom_range(10, 15);
        else v = $urandom_range(0, 9);
        stim.push_back(v);
        last = v;
      end
      gen();
      present(SEQ_LEN, 3);
      good_guesses();
      if ($urandom_range(0, 1) == 1) begin
        int p;
        p = $urandom_range(0, SEQ_LEN - 1);
        gq[p] = (exp_seq[p] + 1 +
                 $urandom_range(0, 8)) % 10;
      end
      guess();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/challenge_sequencer.md
Name: challenge_sequencer

Overview:
Game controller for the Morse decoder's challenge mode. It sequences the 0–9 LFSR random-digit generator to build a SEQ_LEN-digit challenge and stores the digits. It then presents them one at a time to the Morse display/encoder over a valid/ready handshake. Finally it checks the digits the user keys in (from the decoder) against the stored sequence and reports pass or fail.

Parameters:
SEQ_LEN, 4, number of digits per challenge (1..8)
IDX_W, 3, index width; must satisfy 2**IDX_W >= SEQ_LEN
NO_REPEAT, 1, when 1, reject a digit equal to the previous stored digit
MAX_RETRY, 7, consecutive rejected draws after which the current draw is accepted anyway

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  pulse; begin a new challenge (honoured only in IDLE)
replay  in  1  pulse; re-present the stored sequence (honoured only in IDLE with have_seq=1)
abort  in  1  synchronous cancel; returns to IDLE from any state
rng_en  out  1  enable to the random-digit generator
rng_rand  in  4  digit from the generator, registered one cycle after rng_en
digit_out  out  4  challenge digit to the display
digit_valid  out  1  digit_out is valid
digit_ready  in  1  display accepts digit_out
guess_digit  in  4  decoded user digit
guess_valid  in  1  one-cycle strobe qualifying guess_digit
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when checking completes
pass  out  1  result of the last completed check; held until the next start
have_seq  out  1  a complete sequence is stored

Behaviour:
- States: IDLE, GEN_REQ, GEN_WAIT, GEN_CAP, PRESENT, CHECK, RESULT. Registered state; outputs are Moore decodes or registers.
- Reset (rst=0, asynchronous): state=IDLE; idx=0; retry count=0; all storage=0. Outputs: rng_en=0, digit_out=0, digit_valid=0, busy=0, done=0, pass=0, have_seq=0.
- IDLE:
  - start=1 → GEN_REQ; idx=0; pass=0; have_seq=0.
  - Else replay=1 with have_seq=1 → PRESENT; idx=0.
  - start has priority over replay.
- GEN_REQ: rng_en=1 for exactly this cycle → GEN_WAIT.
- GEN_WAIT: one cycle for the generator to register rng_rand → GEN_CAP.
- GEN_CAP: candidate = rng_rand. Reject if either condition holds:
  - candidate > 9;
  - NO_REPEAT=1, idx>0 and candidate == mem[idx-1].
- On reject with retry < MAX_RETRY: retry++ and go to GEN_REQ.
- Otherwise (accept, or retry count exhausted with candidate ≤ 9): mem[idx] = candidate and retry=0.
  - If exhausted with candidate > 9, store candidate − 10 (the generator may legitimately hold a stale value).
  - After storing: if idx == SEQ_LEN−1, set have_seq=1, idx=0 and go to PRESENT; else idx++ and go to GEN_REQ.
- Nominal cost: 3 cycles per digit. With SEQ_LEN=4 and no retries, PRESENT is entered 12 clocks after the start edge.
- PRESENT:
  - digit_valid=1 and digit_out=mem[idx]; both held stable until digit_valid & digit_ready.
  - On transfer: if idx == SEQ_LEN−1, go to CHECK with idx=0; else idx++. A new digit appears on the next cycle.
  - digit_ready while digit_valid=0 is ignored.
- CHECK: waits for guess_valid; guess_valid outside CHECK is ignored.
  - guess_digit != mem[idx]: pass=0 → RESULT (first mismatch ends the check).
  - Match with idx == SEQ_LEN−1: pass=1 → RESULT.
  - Match otherwise: idx++.
- RESULT: done=1 for one cycle → IDLE. pass and have_seq remain held.
- abort=1 in any non-IDLE state:
  - Next state IDLE; digit_valid drops next cycle; no done pulse; pass=0.
  - have_seq=0 if aborted during GEN_*; otherwise unchanged.
  - abort beats start and replay in the same cycle.
- start or replay while busy: ignored, no effect.
- idx wraps only by explicit reset to 0; it never exceeds SEQ_LEN−1.

Test Plan:
1. Reset, then start; stub returns 3,7,1,9. Required: rng_en pulses at 3-cycle spacing; digit_valid rises 12 clocks after start; digits 3,7,1,9 delivered in order. With digit_ready held low 5 cycles on digit 2: digit_out stays 7.
2. Present complete; guesses 3,7,1,9. Required: done pulse for one cycle, pass=1, busy=0, have_seq=1.
3. Same sequence; guesses 3,5. Required: done right after the second guess, pass=0; a further guess is ignored.
4. NO_REPEAT=1; stub returns 4,4,4,6 on the first digit-2 draws. Required: two retries (extra rng_en pulses); stored sequence 4,6. Stub stuck at 4: after MAX_RETRY=7 retries, 4 is accepted.
5. Stub returns 12 (out of range) eight times. Required: 7 retries, then 2 stored.
6. Abort mid-PRESENT, then replay. Required: IDLE with no done pulse; replay re-presents the identical digits without any rng_en. Separately, rst asserted mid-GEN: all outputs 0 immediately.
